// File: rtl/posit8_encoder_if.sv
// Handshake bundle between the decoded-domain arithmetic and the posit8 encoder:
// decoded (scale, fraction) request on one side, packed posit result on the other.
interface posit8_encoder_if;
    logic               in_valid;
    logic               in_ready;
    logic               in_nar;
    logic signed [3:0]  scale;
    logic signed [11:0] frac;
    logic               out_valid;
    logic               out_ready;
    logic [7:0]         posit;

    modport master (
        output in_valid,
        output in_nar,
        output scale,
        output frac,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  posit
    );

    modport slave (
        input  in_valid,
        input  in_nar,
        input  scale,
        input  frac,
        input  out_ready,
        output in_ready,
        output out_valid,
        output posit
    );
endinterface

// File: rtl/posit8_encoder.sv
// Multi-cycle encoder: decoded (scale, Q3.9 fraction) -> 8-bit posit, es = 0.
// Normalizes one bit per cycle, then packs with round-to-nearest-even and saturation.
module posit8_encoder (
    input  logic            clk,
    input  logic            rst_n,
    posit8_encoder_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        PACK = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic               sign_r;
    logic               nar_r;
    logic               sticky_r;
    logic [11:0]        mag_r;
    logic signed [5:0]  escale_r;
    logic [7:0]         posit_r;

    logic [11:0]        frac_u;
    logic [11:0]        frac_abs;
    logic               norm_stop;
    logic               shift_right;

    // Magnitude fits 12 bits unsigned; -2048 maps onto 0x800 naturally.
    assign frac_u   = bus.frac;
    assign frac_abs = frac_u[11] ? (~frac_u + 12'd1) : frac_u;

    // Normalized means the hidden one sits at mag[9] (value in [1,2)).
    assign norm_stop   = nar_r || (mag_r == 12'd0) || (mag_r[11:9] == 3'b001);
    assign shift_right = (mag_r[11:10] != 2'b00);

    // Keep guard/lsb/sticky logic apart so the saturating corner cases stay visible.
    function automatic logic [6:0] round_sat(
        input logic [6:0] kept,
        input logic       guard,
        input logic       sticky
    );
        logic [7:0] sum;
        sum = {1'b0, kept} + {7'd0, guard & (kept[0] | sticky)};
        if (sum[7])
            return 7'h7F;
        else if (sum[6:0] == 7'd0)
            return 7'h01;
        else
            return sum[6:0];
    endfunction

    function automatic logic [7:0] encode_posit(
        input logic               sgn,
        input logic               nar,
        input logic               stk,
        input logic [11:0]        m,
        input logic signed [5:0]  k
    );
        logic [7:0]  regime;
        logic [3:0]  rlen;
        logic [2:0]  nk;
        logic [17:0] field;
        logic [6:0]  mag7;
        logic [7:0]  body;
        regime = 8'd0;
        rlen   = 4'd0;
        nk     = 3'd0;
        field  = 18'd0;
        mag7   = 7'd0;
        if (nar)
            return 8'h80;
        if (m == 12'd0)
            return 8'h00;
        if (k > 6'sd6) begin
            mag7 = 7'h7F;
        end else if (k < -6'sd6) begin
            mag7 = 7'h01;
        end else begin
            if (!k[5]) begin
                // k+1 ones then a terminating zero, left-aligned in 8 bits
                regime = ~(8'hFF >> (k[2:0] + 3'd1));
                rlen   = {1'b0, k[2:0]} + 4'd2;
            end else begin
                // -k zeros then a terminating one
                nk     = ~k[2:0] + 3'd1;
                regime = 8'h80 >> nk;
                rlen   = {1'b0, nk} + 4'd1;
            end
            // Fraction bits follow the regime directly; top 7 bits are kept.
            field = {regime, 10'd0} | ({m[8:0], 9'd0} >> rlen);
            mag7  = round_sat(field[17:11], field[10], (|field[9:0]) | stk);
        end
        body = {1'b0, mag7};
        return sgn ? (8'd0 - body) : body;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.in_valid)  state_next = NORM;
            NORM: if (norm_stop)     state_next = PACK;
            PACK:                    state_next = DONE;
            DONE: if (bus.out_ready) state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_r   <= 1'b0;
            nar_r    <= 1'b0;
            sticky_r <= 1'b0;
            mag_r    <= 12'd0;
            escale_r <= 6'sd0;
            posit_r  <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sign_r   <= frac_u[11];
                        mag_r    <= frac_abs;
                        escale_r <= {{2{bus.scale[3]}}, bus.scale};
                        sticky_r <= 1'b0;
                        nar_r    <= bus.in_nar;
                    end
                end
                NORM: begin
                    if (!norm_stop) begin
                        if (shift_right) begin
                            mag_r    <= mag_r >> 1;
                            sticky_r <= sticky_r | mag_r[0];
                            escale_r <= escale_r + 6'sd1;
                        end else begin
                            mag_r    <= mag_r << 1;
                            escale_r <= escale_r - 6'sd1;
                        end
                    end
                end
                PACK: begin
                    posit_r <= encode_posit(sign_r, nar_r, sticky_r, mag_r, escale_r);
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decode registered state only; nothing flows from inputs to outputs.
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.posit     = posit_r;

endmodule

// File: tb/tb_posit8_encoder.sv
// Self-checking bench for posit8_encoder: directed vectors, randomized pairs against
// a value-domain nearest-posit model, backpressure and asynchronous reset.
module tb_posit8_encoder;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    posit8_encoder_if bus();

    posit8_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Exact value of positive posit pattern p (1..127), es=0, in units of 2^-20.
    function automatic longint pval(input int p);
        int first, run, k, fb, f;
        first = (p >> 6) & 1;
        run   = 0;
        for (int b = 6; b >= 0; b--) begin
            if (((p >> b) & 1) == first) run++;
            else break;
        end
        k  = first ? run - 1 : -run;
        fb = 7 - run - 1;
        if (fb < 0) fb = 0;
        f  = p & ((1 << fb) - 1);
        return longint'((1 << fb) + f) <<< (20 + k - fb);
    endfunction

    // Nearest posit to frac/512 * 2^scale, ties to the even pattern, clamped to minpos..maxpos.
    function automatic logic [7:0] ref_posit(input logic nar, input logic signed [3:0] sc,
                                              input logic signed [11:0] fr);
        longint v, lo, hi;
        int ia, m;
        logic [7:0] r;
        if (nar) return 8'h80;
        if (fr == 12'sd0) return 8'h00;
        ia = fr;
        if (ia < 0) ia = -ia;
        v = longint'(ia) <<< (int'(sc) + 11);
        m = 1;
        if (v >= pval(127)) m = 127;
        else if (v <= pval(1)) m = 1;
        else begin
            for (int p = 1; p < 127; p++) begin
                if (v >= pval(p) && v < pval(p + 1)) begin
                    lo = v - pval(p);
                    hi = pval(p + 1) - v;
                    if (lo < hi) m = p;
                    else if (hi < lo) m = p + 1;
                    else m = (p % 2 == 0) ? p : p + 1;
                    break;
                end
            end
        end
        r = 8'(m);
        return fr[11] ? (8'd0 - r) : r;
    endfunction

    function automatic int ref_lat(input logic nar, input logic signed [11:0] fr);
        int ia, s;
        if (nar || fr == 12'sd0) return 2;
        ia = fr;
        if (ia < 0) ia = -ia;
        if (ia >= 2048) return 4;
        if (ia >= 1024) return 3;
        s = 0;
        while (ia < 512) begin
            ia = ia * 2;
            s++;
        end
        return 2 + s;
    endfunction

    // Drives one transaction with out_ready high; call at #1 after a rising edge while idle.
    task automatic do_txn(input logic nar, input logic [3:0] sc, input logic [11:0] fr,
                          output logic [7:0] got, output int lat, output logic rdy);
        bus.in_valid  = 1'b1;
        bus.in_nar    = nar;
        bus.scale     = sc;
        bus.frac      = fr;
        bus.out_ready = 1'b1;
        rdy = bus.in_ready;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = -1;
        got = 8'h00;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (bus.out_valid) begin
                lat = c;
                got = bus.posit;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.posit !== 8'h00 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_hold: posit=%h out_valid=%b in_ready=%b, want 00/0/1",
                     bus.posit, bus.out_valid, bus.in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.posit !== 8'h00 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: posit=%h out_valid=%b in_ready=%b, want 00/0/1",
                     bus.posit, bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_directed();
        logic        v_nar [12];
        logic [3:0]  v_sc  [12];
        logic [11:0] v_fr  [12];
        logic [7:0]  v_exp [12];
        int          v_lat [12];
        logic [7:0]  got;
        int          lat;
        logic        rdy;
        v_nar = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        v_sc  = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd7, 4'd0, 4'h8, 4'd0, 4'd3, 4'd0};
        v_fr  = '{12'h200, 12'hE00, 12'h600, 12'h208, 12'h218, 12'h209,
                  12'h200, 12'h001, 12'hE00, 12'h000, 12'h123, 12'h800};
        v_exp = '{8'h40, 8'hC0, 8'h68, 8'h40, 8'h42, 8'h41,
                  8'h7F, 8'h01, 8'hFF, 8'h00, 8'h80, 8'h90};
        v_lat = '{2, 2, 3, 2, 2, 2, 2, 11, 2, 2, 2, 4};
        for (int i = 0; i < 12; i++) begin
            do_txn(v_nar[i], v_sc[i], v_fr[i], got, lat, rdy);
            checks++;
            if (rdy !== 1'b1) begin
                errors++;
                $display("FAIL directed_ready[%0d]: in_ready=%b, want 1", i, rdy);
            end
            checks++;
            if (got !== v_exp[i]) begin
                errors++;
                $display("FAIL directed_posit[%0d] sc=%h fr=%h nar=%b: got %h, want %h",
                         i, v_sc[i], v_fr[i], v_nar[i], got, v_exp[i]);
            end
            checks++;
            if (lat !== v_lat[i]) begin
                errors++;
                $display("FAIL directed_latency[%0d]: got %0d, want %0d", i, lat, v_lat[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [11:0] edges [8];
        logic        nar;
        logic [3:0]  sc;
        logic [11:0] fr;
        logic [7:0]  got;
        logic [7:0]  exp_p;
        int          lat;
        int          exp_l;
        logic        rdy;
        edges = '{12'h800, 12'h7FF, 12'h001, 12'hFFF, 12'h3FF, 12'h400, 12'h1FF, 12'hC00};
        for (int i = 0; i < 200; i++) begin
            nar = ($urandom_range(0, 15) == 0);
            sc  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) fr = edges[$urandom_range(0, 7)];
            else fr = 12'($urandom);
            exp_p = ref_posit(nar, sc, fr);
            exp_l = ref_lat(nar, fr);
            do_txn(nar, sc, fr, got, lat, rdy);
            checks++;
            if (got !== exp_p) begin
                errors++;
                $display("FAIL random_posit[%0d] sc=%h fr=%h nar=%b: got %h, want %h",
                         i, sc, fr, nar, got, exp_p);
            end
            checks++;
            if (lat !== exp_l) begin
                errors++;
                $display("FAIL random_latency[%0d] fr=%h: got %0d, want %0d", i, fr, lat, exp_l);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bus.in_valid  = 1'b1;
        bus.in_nar    = 1'b0;
        bus.scale     = 4'sd0;
        bus.frac      = 12'sh600;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.frac = 12'sh200;  // stays valid; must be ignored while busy
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (bus.out_valid) begin
                lat = c;
                break;
            end
        end
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL bp_latency: got %0d, want 3", lat);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.posit !== 8'h68 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: out_valid=%b posit=%h in_ready=%b, want 1/68/0",
                         i, bus.out_valid, bus.posit, bus.in_ready);
            end
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b, want 0/1",
                     bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset_mid_norm();
        logic [7:0] got;
        int         lat;
        logic       rdy;
        bus.in_valid  = 1'b1;
        bus.in_nar    = 1'b0;
        bus.scale     = 4'sd0;
        bus.frac      = 12'sh001;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.posit !== 8'h00 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midnorm_reset: posit=%h out_valid=%b in_ready=%b, want 00/0/1",
                     bus.posit, bus.out_valid, bus.in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_txn(1'b0, 4'd0, 12'h200, got, lat, rdy);
        checks++;
        if (got !== 8'h40 || lat !== 2) begin
            errors++;
            $display("FAIL midnorm_after: posit=%h lat=%0d, want 40 lat 2", got, lat);
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_nar    = 1'b0;
        bus.scale     = 4'sd0;
        bus.frac      = 12'sd0;
        bus.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_mid_norm();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
